// File: rtl/k423_pkg.sv
// k423 core shared types and widths.
// Holds the PCU state encoding and core-wide address/register widths.
package k423_pkg;

  localparam int unsigned CORE_ADDR_W = 32;
  localparam int unsigned REG_IDX_W   = 5;

  typedef enum logic [1:0] {
    PCU_IDLE     = 2'd0,
    PCU_MEM_WAIT = 2'd1,
    PCU_FLUSH    = 2'd2
  } pcu_state_e;

endpackage

// File: rtl/k423_pcu_perf.sv
// k423 PCU saturating performance counter bank.
// Ports: clk_i, rst_n_i, inc_lu_i/inc_mem_i/inc_flush_i (count enables),
// lu_cnt_o/mem_cnt_o/flush_cnt_o (PERF_W-bit counts, saturate at all-ones).
module k423_pcu_perf #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              inc_lu_i,
  input  logic              inc_mem_i,
  input  logic              inc_flush_i,
  output logic [PERF_W-1:0] lu_cnt_o,
  output logic [PERF_W-1:0] mem_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  logic [PERF_W-1:0] cnt_q [3];
  logic [PERF_W-1:0] cnt_d [3];
  logic [2:0]        inc;

  assign inc = {inc_flush_i, inc_mem_i, inc_lu_i};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign lu_cnt_o    = cnt_q[0];
  assign mem_cnt_o   = cnt_q[1];
  assign flush_cnt_o = cnt_q[2];

endmodule

// File: rtl/k423_pcu.sv
// k423 pipeline control unit: load-use, dmem-wait and branch-flush control.
// Ports: clk_i, rst_n_i; ID/EX hazard inputs; EX redirect inputs; MEM req/rsp;
// stall/bubble/flush/redirect outputs (combinational). Optional perf counter
// outputs when K423_PCU_PERF_EN is defined.
module k423_pcu
  import k423_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
`ifdef K423_PCU_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   id_stage_vld_i,
  input  logic [REG_IDX_W-1:0]   id_rs1_idx_i,
  input  logic [REG_IDX_W-1:0]   id_rs2_idx_i,
  input  logic                   id_rs1_rd_en_i,
  input  logic                   id_rs2_rd_en_i,
  input  logic                   ex_stage_vld_i,
  input  logic                   ex_is_load_i,
  input  logic [REG_IDX_W-1:0]   ex_rd_idx_i,
  input  logic                   ex_rd_wr_en_i,
  input  logic                   ex_br_redirect_i,
  input  logic [CORE_ADDR_W-1:0] ex_br_tgt_i,
  input  logic                   mem_req_vld_i,
  input  logic                   mem_rsp_vld_i,
  output logic                   pcu_stall_loaduse_o,
  output logic                   pcu_stall_mem_o,
  output logic                   pcu_bubble_ex_o,
  output logic                   pcu_flush_br_o,
  output logic                   pcu_redirect_vld_o,
  output logic [CORE_ADDR_W-1:0] pcu_redirect_pc_o
`ifdef K423_PCU_PERF_EN
  ,
  output logic [PERF_W-1:0]      pcu_perf_lu_cnt_o,
  output logic [PERF_W-1:0]      pcu_perf_mem_cnt_o,
  output logic [PERF_W-1:0]      pcu_perf_flush_cnt_o
`endif
);

  localparam bit         FLUSH_EN = (FLUSH_CYCLES > 1);
  localparam logic [2:0] CNT_LOAD =
    FLUSH_EN ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  pcu_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic mem_stall;
  logic acc;
  logic lu;
  logic flush;
  logic lu_stall;
  logic rs1_hit;
  logic rs2_hit;

  assign mem_stall =
    ((state_q == PCU_IDLE) & mem_req_vld_i & ~mem_rsp_vld_i) |
    ((state_q == PCU_MEM_WAIT) & ~mem_rsp_vld_i);

  // A redirect held off by a dmem stall stays in EX and fires on release.
  assign acc   = ex_br_redirect_i & ~mem_stall;
  assign flush = acc | (state_q == PCU_FLUSH);

  assign rs1_hit = id_rs1_rd_en_i & (id_rs1_idx_i == ex_rd_idx_i);
  assign rs2_hit = id_rs2_rd_en_i & (id_rs2_idx_i == ex_rd_idx_i);

  assign lu = ex_stage_vld_i & ex_is_load_i & ex_rd_wr_en_i &
              (ex_rd_idx_i != '0) & id_stage_vld_i &
              (rs1_hit | rs2_hit);

  // The bubble moves the load to MEM, so the hazard clears next cycle.
  assign lu_stall = lu & ~mem_stall & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PCU_IDLE: begin
        if (mem_stall) begin
          state_d = PCU_MEM_WAIT;
        end else if (acc && FLUSH_EN) begin
          state_d = PCU_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      PCU_MEM_WAIT: begin
        if (mem_rsp_vld_i) begin
          state_d = PCU_IDLE;
          if (acc && FLUSH_EN) begin
            state_d = PCU_FLUSH;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      PCU_FLUSH: begin
        if (acc && FLUSH_EN) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == 3'd0) begin
          state_d = PCU_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = PCU_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PCU_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with rst_n_i keeps outputs quiet while reset is held,
  // even though they are otherwise purely combinational.
  assign pcu_stall_mem_o     = rst_n_i & mem_stall;
  assign pcu_stall_loaduse_o = rst_n_i & lu_stall;
  assign pcu_bubble_ex_o     = rst_n_i & lu_stall;
  assign pcu_flush_br_o      = rst_n_i & flush;
  assign pcu_redirect_vld_o  = rst_n_i & acc;
  assign pcu_redirect_pc_o   =
    (rst_n_i & acc) ? ex_br_tgt_i : '0;

`ifdef K423_PCU_PERF_EN
  k423_pcu_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .inc_lu_i    (lu_stall),
    .inc_mem_i   (mem_stall),
    .inc_flush_i (acc),
    .lu_cnt_o    (pcu_perf_lu_cnt_o),
    .mem_cnt_o   (pcu_perf_mem_cnt_o),
    .flush_cnt_o (pcu_perf_flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_k423_pcu.sv
// Directed scoreboard bench for k423_pcu (FLUSH_CYCLES=3).
// Expected output vectors are queued at drive time and popped at sample time.
module tb_k423_pcu;
  import k423_pkg::*;

  typedef struct packed {
    logic                   lu;
    logic                   mem;
    logic                   bub;
    logic                   fl;
    logic                   rv;
    logic [CORE_ADDR_W-1:0] pc;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   id_vld;
  logic [REG_IDX_W-1:0]   rs1, rs2;
  logic                   rs1_en, rs2_en;
  logic                   ex_vld, ex_ld, ex_we;
  logic [REG_IDX_W-1:0]   rd;
  logic                   br;
  logic [CORE_ADDR_W-1:0] tgt;
  logic                   req, rsp;
  logic                   o_lu, o_mem, o_bub, o_fl, o_rv;
  logic [CORE_ADDR_W-1:0] o_pc;
`ifdef K423_PCU_PERF_EN
  logic [31:0] p_lu, p_mem, p_fl;
`endif

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  k423_pcu #(
    .FLUSH_CYCLES (3)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .id_stage_vld_i      (id_vld),
    .id_rs1_idx_i        (rs1),
    .id_rs2_idx_i        (rs2),
    .id_rs1_rd_en_i      (rs1_en),
    .id_rs2_rd_en_i      (rs2_en),
    .ex_stage_vld_i      (ex_vld),
    .ex_is_load_i        (ex_ld),
    .ex_rd_idx_i         (rd),
    .ex_rd_wr_en_i       (ex_we),
    .ex_br_redirect_i    (br),
    .ex_br_tgt_i         (tgt),
    .mem_req_vld_i       (req),
    .mem_rsp_vld_i       (rsp),
    .pcu_stall_loaduse_o (o_lu),
    .pcu_stall_mem_o     (o_mem),
    .pcu_bubble_ex_o     (o_bub),
    .pcu_flush_br_o      (o_fl),
    .pcu_redirect_vld_o  (o_rv),
    .pcu_redirect_pc_o   (o_pc)
`ifdef K423_PCU_PERF_EN
    ,
    .pcu_perf_lu_cnt_o    (p_lu),
    .pcu_perf_mem_cnt_o   (p_mem),
    .pcu_perf_flush_cnt_o (p_fl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t e(input logic lu, input logic mem,
                             input logic fl, input logic rv,
                             input logic [CORE_ADDR_W-1:0] pc);
    exp_t r;
    r.lu  = lu;
    r.mem = mem;
    r.bub = lu;
    r.fl  = fl;
    r.rv  = rv;
    r.pc  = pc;
    return r;
  endfunction

  task automatic clr();
    id_vld = 0; rs1 = 0; rs2 = 0; rs1_en = 0; rs2_en = 0;
    ex_vld = 0; ex_ld = 0; ex_we = 0; rd = 0;
    br = 0; tgt = 0; req = 0; rsp = 0;
  endtask

  // lw x5 in EX, ID reads a=rs1, b=rs2
  task automatic hz(input logic [4:0] a, input logic [4:0] b,
                    input logic ea, input logic eb);
    ex_vld = 1; ex_ld = 1; ex_we = 1; rd = 5'd5;
    id_vld = 1; rs1 = a; rs2 = b; rs1_en = ea; rs2_en = eb;
  endtask

  task automatic chk(input string tag, input exp_t x);
    exp_t obs, ex;
    sb.push_back(x);
    @(negedge clk);
    obs = {o_lu, o_mem, o_bub, o_fl, o_rv, o_pc};
    ex  = sb.pop_front();
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    checks++;
    assert (dut.state_q === PCU_IDLE) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, dut.state_q, PCU_IDLE);
    end
  endtask

  localparam logic [31:0] T1 = 32'h8000_0100;
  localparam logic [31:0] T2 = 32'h8000_0200;
  localparam logic [31:0] T3 = 32'h8000_0300;

  initial begin
    clr();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", e(0, 0, 0, 0, 0));
`ifdef K423_PCU_PERF_EN
    checks++;
    assert ({p_lu, p_mem, p_fl} === 96'd0) else begin
      failures++;
      $error("FAIL rst_perf observed=%h expected=0", {p_lu, p_mem, p_fl});
    end
`endif
    rst_n = 1;
    chk("idle", e(0, 0, 0, 0, 0));

    // load-use
    hz(5'd5, 5'd1, 1, 1);
    chk("lu_rs1", e(1, 0, 0, 0, 0));
    ex_vld = 0; ex_ld = 0; ex_we = 0;
    chk("lu_after", e(0, 0, 0, 0, 0));
    hz(5'd1, 5'd5, 1, 1);
    chk("lu_rs2", e(1, 0, 0, 0, 0));
    hz(5'd1, 5'd5, 1, 0);
    chk("lu_rs2_noen", e(0, 0, 0, 0, 0));
    hz(5'd0, 5'd0, 1, 1);
    rd = 5'd0;
    chk("lu_x0", e(0, 0, 0, 0, 0));
    hz(5'd5, 5'd1, 1, 1);
    ex_ld = 0;
    chk("lu_noload", e(0, 0, 0, 0, 0));
    hz(5'd5, 5'd1, 1, 1);
    id_vld = 0;
    chk("lu_noidvld", e(0, 0, 0, 0, 0));
    clr();

    // mem wait: req at T, rsp at T+3
    req = 1;
    chk("mem_t0", e(0, 1, 0, 0, 0));
    req = 0;
    chk("mem_t1", e(0, 1, 0, 0, 0));
    chk("mem_t2", e(0, 1, 0, 0, 0));
    rsp = 1;
    chk("mem_t3", e(0, 0, 0, 0, 0));
    chk_idle("mem_t4_state");
    clr();
    chk("mem_t4", e(0, 0, 0, 0, 0));
    req = 1; rsp = 1;
    chk("mem_same_cyc", e(0, 0, 0, 0, 0));
    clr();

    // redirect with 3-cycle flush
    br = 1; tgt = T1;
    chk("br_acc", e(0, 0, 1, 1, T1));
    clr();
    chk("br_fl2", e(0, 0, 1, 0, 0));
    chk("br_fl3", e(0, 0, 1, 0, 0));
    chk("br_done", e(0, 0, 0, 0, 0));

    // redirect inside FLUSH reloads the count
    br = 1; tgt = T1;
    chk("rl_acc1", e(0, 0, 1, 1, T1));
    clr();
    chk("rl_fl", e(0, 0, 1, 0, 0));
    br = 1; tgt = T2;
    chk("rl_acc2", e(0, 0, 1, 1, T2));
    clr();
    chk("rl_fl2", e(0, 0, 1, 0, 0));
    chk("rl_fl3", e(0, 0, 1, 0, 0));
    chk("rl_done", e(0, 0, 0, 0, 0));

    // redirect + load-use + mem stall together
    hz(5'd5, 5'd1, 1, 1);
    br = 1; tgt = T3; req = 1;
    chk("pri_t0", e(0, 1, 0, 0, 0));
    req = 0;
    chk("pri_t1", e(0, 1, 0, 0, 0));
    rsp = 1;
    chk("pri_rsp", e(0, 0, 1, 1, T3));
    br = 0; rsp = 0; tgt = 0;
    chk("pri_fl2", e(0, 0, 1, 0, 0));
    chk("pri_fl3", e(0, 0, 1, 0, 0));
    chk("pri_lu", e(1, 0, 0, 0, 0));
    clr();

    // async reset inside MEM_WAIT
    req = 1;
    chk("rmw_enter", e(0, 1, 0, 0, 0));
    #2 rst_n = 0;
    chk("rmw_rst", e(0, 0, 0, 0, 0));
    chk_idle("rmw_state");
`ifdef K423_PCU_PERF_EN
    checks++;
    assert ({p_lu, p_mem, p_fl} === 96'd0) else begin
      failures++;
      $error("FAIL rmw_perf observed=%h expected=0", {p_lu, p_mem, p_fl});
    end
`endif
    req = 0;
    rst_n = 1;
    chk("rmw_after", e(0, 0, 0, 0, 0));

    // async reset inside FLUSH
    br = 1; tgt = T1;
    chk("rfl_acc", e(0, 0, 1, 1, T1));
    clr();
    #2 rst_n = 0;
    chk("rfl_rst", e(0, 0, 0, 0, 0));
    rst_n = 1;
    chk("rfl_after", e(0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
